bip_fetch_control: RTL
======================

Name: bip_fetch_control

Overview:
Fetch/execution sequencer for the BIP processor. Owns the program counter register, computes PC+1 with modulo-2^len_addr wrap, and drives the global datapath enable. It starts execution on request, stops on the HLT opcode, and keeps an executed-cycle count for the debug unit. Sits between the debug/UART control unit and the BIP datapath, and addresses program memory directly.

Parameters:
len_addr, 11, PC and program-memory address width
len_opcode, 5, opcode field width of the fetched instruction
len_cycles, 16, cycle counter width
opcode_halt, 0, opcode value that stops execution
sumando, 1, PC increment per executed instruction

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level sampled each cycle; begins or restarts execution from address 0
opcode  input  len_opcode  opcode of the instruction at pc; combinational program-memory read, valid in the same cycle as pc
pc  output  len_addr  program-memory address (registered)
pc_en  output  1  datapath enable; high only in cycles where the current instruction executes
running  output  1  high while in RUN
halted  output  1  high while in HALT
done  output  1  one-cycle pulse on entry to HALT
cycle_count  output  len_cycles  executed-instruction count since last start (registered)

Behaviour:
- States: IDLE, RUN, HALT. Registered state; outputs running/halted decoded from state.
- Reset (sync, dominant over all inputs, valid from any state incl. mid-RUN): state=IDLE, pc=0, cycle_count=0, done=0. pc_en/running/halted therefore 0.
- IDLE: pc held 0. start=1 -> RUN next cycle; pc=0; cycle_count cleared to 0.
- RUN, opcode != opcode_halt: pc_en=1 (combinational); next edge pc <= pc + sumando (truncated to len_addr bits, so all-ones wraps to 0 and execution continues); cycle_count <= cycle_count+1, saturating at all-ones.
- RUN, opcode == opcode_halt: pc_en=0 in that cycle; pc unchanged; cycle_count still increments (HLT counted); next state HALT; done=1 for exactly the first HALT cycle.
- start while in RUN: ignored.
- HALT: pc, cycle_count frozen, pc_en=0, halted=1. start=1 -> RUN next cycle with pc=0, cycle_count=0 (restart). done does not re-pulse while remaining in HALT.
- Latency: start sampled at edge N -> running=1 and pc_en valid from cycle N+1; first instruction at address 0 executes in cycle N+1.
- HLT at address 0: one RUN cycle, pc stays 0, cycle_count=1, then HALT.

Optional Feature:
Macro STEP_MODE_EN.
- Defined: adds ports step_mode (input, 1) and step (input, 1). While step_mode=1, a RUN cycle advances only when step=1: pc_en = RUN && step && opcode!=opcode_halt; pc/cycle_count update only on step cycles; HLT is recognised only on a step cycle. When step_mode=0, behaviour matches the free-running case. step is ignored outside RUN.
- Not defined: the ports are absent and RUN always free-runs as described above.

Test Plan:
- Reset mid-RUN at pc=5 -> next cycle pc=0, state IDLE, pc_en=0, cycle_count=0, done=0.
- Program memory: HLT at address 3, start pulse -> pc sequence 0,1,2,3; pc_en=1 for 3 cycles and 0 at pc=3; done one cycle; halted=1; cycle_count=4; pc stays 3.
- len_addr=3, no HLT in memory -> pc 6,7,0,1 with continuous pc_en=1; running stays 1.
- len_cycles=2, HLT at address 6 -> cycle_count saturates at 3; pc reaches 6; halts.
- In HALT, start=1 -> pc=0, cycle_count=0, running=1 next cycle; start held during RUN has no effect on pc.
- STEP_MODE_EN, step_mode=1, step pulsed every 3rd cycle -> pc advances by 1 only after each step; pc_en high only on step cycles; HLT at address 2 halts on the 3rd step.

Source files
------------

// File: rtl/bip_fetch_control.sv
//==============================================================================
// bip_fetch_control : BIP fetch/execution sequencer (PC, datapath enable,
// executed-instruction counter). Optional macro STEP_MODE_EN adds single-step.
// Revision: 1.0
//==============================================================================
`default_nettype none

module bip_fetch_control #(
   parameter int len_addr    = 11,
   parameter int len_opcode  = 5,
   parameter int len_cycles  = 16,
   parameter int opcode_halt = 0,
   parameter int sumando     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [len_opcode-1:0] opcode,
`ifdef STEP_MODE_EN
   input  logic                  step_mode,
   input  logic                  step,
`endif
   output logic [len_addr-1:0]   pc,
   output logic                  pc_en,
   output logic                  running,
   output logic                  halted,
   output logic                  done,
   output logic [len_cycles-1:0] cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [len_addr-1:0]   pc_q, pc_d;
   logic [len_cycles-1:0] cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  w_is_halt;
   logic                  w_advance;

   assign w_is_halt = (opcode == len_opcode'(opcode_halt));

   // A RUN cycle only takes effect when single-stepping is off or a step is given
`ifdef STEP_MODE_EN
   assign w_advance = !step_mode || step;
`else
   assign w_advance = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      pc_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            pc_d = '0;
            if (start) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (w_advance) begin
               // The HLT instruction itself is counted
               cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
               if (w_is_halt) begin
                  state_d = S_HALT;
                  done_d  = 1'b1;
               end else begin
                  pc_en = 1'b1;
                  pc_d  = pc_q + len_addr'(sumando);
               end
            end
         end
         S_HALT: begin
            if (start) begin
               state_d = S_RUN;
               pc_d    = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign pc          = pc_q;
   assign cycle_count = cnt_q;
   assign done        = done_q;
   assign running     = (state_q == S_RUN);
   assign halted      = (state_q == S_HALT);

endmodule

`default_nettype wire
